// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the UART transmit framer.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    // Line-driver select codes for the registered TX output
    typedef enum logic [1:0] {
        SEL_START  = 2'b00,
        SEL_DATA   = 2'b01,
        SEL_PARITY = 2'b10,
        SEL_STOP   = 2'b11
    } tx_sel_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_tx_parity_calc.sv
// Combinational parity generator over the latched payload.
module uart_tx_parity_calc
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  par_typ,
    output logic                  par_bit
);

    assign par_bit = (^data) ^ (par_typ == PAR_ODD);

endmodule

// File: rtl/uart_tx_framer.sv
// UART transmit framer: start, payload, optional parity, stop bits; one bit per CLK.
module uart_tx_framer
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int STOP_BITS  = 1,
    parameter int LSB_FIRST  = 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT,
    output logic                  BUSY,
    output logic                  READY
);

    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0] LAST_STOP = CNT_W'(STOP_BITS - 1);

    state_t                state, state_n;
    tx_sel_t               sel;
    logic [CNT_W-1:0]      cnt, cnt_n;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  par_en_q;
    logic                  par_typ_q;
    logic                  par_bit;
    logic                  tx_q, tx_n;
    logic                  accept;
    logic                  last_stop;

    uart_tx_parity_calc #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_parity (
        .data   (data_q),
        .par_typ(par_typ_q),
        .par_bit(par_bit)
    );

    function automatic logic payload_bit(input logic [DATA_WIDTH-1:0] d,
                                         input logic [CNT_W-1:0]      idx);
        if (LSB_FIRST != 0)
            return d[idx];
        return d[LAST_BIT - idx];
    endfunction

    // The counter indexes payload bits in DATA and is reused to count stop bits in STOP
    assign last_stop = (state == STOP) && (cnt == LAST_STOP);
    assign READY     = (state == IDLE) || last_stop;
    assign BUSY      = (state != IDLE);
    assign accept    = DATA_VALID && READY;
    assign TX_OUT    = tx_q;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        sel     = SEL_STOP;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_n = START;
                    sel     = SEL_START;
                end
            end
            START: begin
                state_n = DATA;
                cnt_n   = '0;
                sel     = SEL_DATA;
            end
            DATA: begin
                if (cnt == LAST_BIT) begin
                    cnt_n = '0;
                    if (par_en_q) begin
                        state_n = PARITY;
                        sel     = SEL_PARITY;
                    end else begin
                        state_n = STOP;
                    end
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                    sel   = SEL_DATA;
                end
            end
            PARITY: begin
                state_n = STOP;
            end
            STOP: begin
                if (last_stop) begin
                    cnt_n = '0;
                    if (accept) begin
                        state_n = START;
                        sel     = SEL_START;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // The line register loads the bit belonging to the next state, so the
    // start bit appears on the same edge that accepts the request
    always_comb begin
        tx_n = 1'b1;
        unique case (sel)
            SEL_START:  tx_n = 1'b0;
            SEL_DATA:   tx_n = payload_bit(data_q, cnt_n);
            SEL_PARITY: tx_n = par_bit;
            default:    tx_n = 1'b1;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= IDLE;
            cnt       <= '0;
            tx_q      <= 1'b1;
            data_q    <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            tx_q  <= tx_n;
            if (accept) begin
                data_q    <= P_DATA;
                par_en_q  <= PAR_EN;
                par_typ_q <= PAR_TYP;
            end
        end
    end

endmodule
